// File: rtl/cam_read_pkg.sv
// Shared FSM state type and parameter limits for the windowed camera capture block.
package cam_read_pkg;

  localparam int BPP_MIN = 1;
  localparam int BPP_MAX = 4;
  localparam int PHASE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS_HI,
    S_WAIT_VS_LO,
    S_CAPTURE
  } cam_state_e;

endpackage

// File: rtl/cam_window_read_if.sv
// Byte stream into the pixel assembler and assembled pixels back out.
interface cam_window_read_if #(
  parameter int DATA_W = 8,
  parameter int BPP    = 2
);
  logic                  smp_vld;
  logic [DATA_W-1:0]     smp_dat;
  logic                  line_start;
  logic                  line_end;
  logic                  flush;
  logic                  pix_vld;
  logic [DATA_W*BPP-1:0] pix_dat;
  logic                  part_err;

  modport master (
    output smp_vld, smp_dat, line_start, line_end, flush,
    input  pix_vld, pix_dat, part_err
  );

  modport slave (
    input  smp_vld, smp_dat, line_start, line_end, flush,
    output pix_vld, pix_dat, part_err
  );
endinterface

// File: rtl/cam_byte_pack.sv
// Packs BPP camera bytes into one pixel (first byte in MSBs); pix_vld is combinational on the last byte.
// No backpressure; a line ending mid-pixel drops the partial pixel and raises part_err.
module cam_byte_pack
  import cam_read_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BPP    = 2
) (
  input  logic            clk,
  input  logic            rst,
  cam_window_read_if.slave bp
);
  localparam int                 PIX_W = DATA_W * BPP;
  localparam logic [PHASE_W-1:0] LAST  = PHASE_W'(BPP - 1);

  logic [PHASE_W-1:0] phase_q, phase_d, phase_cur;
  logic [PIX_W-1:0]   shift_q, shift_d, shift_nxt;
  logic               pix_vld, part_err;

  always_comb begin
    // A rising href starts a fresh pixel even if the previous line was left mid-pixel.
    phase_cur = bp.line_start ? '0 : phase_q;
    shift_nxt = (shift_q << DATA_W) | PIX_W'(bp.smp_dat);
    phase_d   = phase_q;
    shift_d   = shift_q;
    pix_vld   = 1'b0;
    part_err  = 1'b0;
    if (bp.flush) begin
      phase_d = '0;
    end else if (bp.line_end) begin
      phase_d  = '0;
      part_err = (phase_q != '0);
    end else if (bp.smp_vld) begin
      shift_d = shift_nxt;
      if (phase_cur == LAST) begin
        phase_d = '0;
        pix_vld = 1'b1;
      end else begin
        phase_d = phase_cur + PHASE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      shift_q <= '0;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
    end
  end

  assign bp.pix_vld  = pix_vld;
  assign bp.pix_dat  = shift_nxt;
  assign bp.part_err = part_err;

endmodule

// File: rtl/cam_window_read.sv
// Crops a window from a vsync/href camera stream; pixel outputs are registered one cycle after the last byte.
// No backpressure (camera cannot stall). Define CAM_WINDOW_READ_DECIMATE_EN for 2:1 decimation on both axes.
module cam_window_read
  import cam_read_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BPP    = 2,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic                  p_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [DATA_W-1:0]     p_data,
  input  logic [XW-1:0]         win_x0,
  input  logic [XW-1:0]         win_x1,
  input  logic [YW-1:0]         win_y0,
  input  logic [YW-1:0]         win_y1,
  output logic [DATA_W*BPP-1:0] pixel_data,
  output logic [XW-1:0]         pixel_x,
  output logic [YW-1:0]         pixel_y,
  output logic                  pixel_done,
  output logic                  done,
  output logic                  busy,
  output logic                  line_err
);
  localparam int PIX_W = DATA_W * BPP;

  if (BPP < BPP_MIN || BPP > BPP_MAX) begin : g_bpp_range
    $error("cam_window_read: BPP outside legal range");
  end

  cam_state_e       state_q, state_d;
  logic             cont_q, cont_d;
  logic [XW-1:0]    x0_q, x0_d, x1_q, x1_d, col_q, col_d;
  logic [YW-1:0]    y0_q, y0_d, y1_q, y1_d, row_q, row_d;
  logic             href_q, href_d;
  logic [PIX_W-1:0] pixel_data_q, pixel_data_d;
  logic [XW-1:0]    pixel_x_q, pixel_x_d;
  logic [YW-1:0]    pixel_y_q, pixel_y_d;
  logic             pixel_done_q, pixel_done_d;
  logic             done_q, done_d;
  logic             line_err_q, line_err_d;
  logic             capturing, frame_end, enter_cap, busy_c;
  logic             href_rise, href_fall, in_win;

  cam_window_read_if #(.DATA_W(DATA_W), .BPP(BPP)) bp_if ();

  cam_byte_pack #(.DATA_W(DATA_W), .BPP(BPP)) u_pack (
    .clk (p_clock),
    .rst (reset),
    .bp  (bp_if.slave)
  );

  always_ff @(posedge p_clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start)  state_d = S_WAIT_VS_HI;
      S_WAIT_VS_HI: if (vsync)  state_d = S_WAIT_VS_LO;
      S_WAIT_VS_LO: if (!vsync) state_d = S_CAPTURE;
      S_CAPTURE:    if (vsync)  state_d = cont_q ? S_WAIT_VS_LO : S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // vsync wins over href in CAPTURE, so a byte coincident with frame end is never sampled.
  always_comb begin
    busy_c    = (state_q != S_IDLE);
    capturing = (state_q == S_CAPTURE) && !vsync;
    frame_end = (state_q == S_CAPTURE) && vsync;
    enter_cap = (state_q == S_WAIT_VS_LO) && !vsync;
    done_d    = frame_end;
  end

  assign bp_if.smp_vld    = capturing && href;
  assign bp_if.smp_dat    = p_data;
  assign bp_if.line_start = href_rise;
  assign bp_if.line_end   = href_fall;
  assign bp_if.flush      = frame_end || enter_cap;

  always_comb begin
    cont_d = cont_q;
    x0_d   = x0_q;
    x1_d   = x1_q;
    y0_d   = y0_q;
    y1_d   = y1_q;
    if (state_q == S_IDLE && start) begin
      cont_d = continuous;
      x0_d   = win_x0;
      x1_d   = win_x1;
      y0_d   = win_y0;
      y1_d   = win_y1;
    end

    href_d    = capturing && href;
    href_rise = capturing && href && !href_q;
    href_fall = capturing && !href && href_q;

    col_d = col_q;
    row_d = row_q;
    if (enter_cap) begin
      col_d = '0;
      row_d = '0;
    end else if (href_fall) begin
      col_d = '0;
      row_d = (row_q == '1) ? row_q : row_q + YW'(1);
    end else if (bp_if.pix_vld) begin
      col_d = (col_q == '1) ? col_q : col_q + XW'(1);
    end

    in_win = (col_q >= x0_q) && (col_q <= x1_q) && (row_q >= y0_q) && (row_q <= y1_q);
`ifdef CAM_WINDOW_READ_DECIMATE_EN
    in_win = in_win && !col_q[0] && !row_q[0];
`endif

    pixel_done_d = bp_if.pix_vld && in_win;
    pixel_data_d = bp_if.pix_vld ? bp_if.pix_dat : pixel_data_q;
    pixel_x_d    = bp_if.pix_vld ? col_q : pixel_x_q;
    pixel_y_d    = bp_if.pix_vld ? row_q : pixel_y_q;
    line_err_d   = bp_if.part_err;
  end

  always_ff @(posedge p_clock) begin
    if (reset) begin
      cont_q       <= 1'b0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      href_q       <= 1'b0;
      pixel_data_q <= '0;
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      pixel_done_q <= 1'b0;
      done_q       <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      cont_q       <= cont_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      col_q        <= col_d;
      row_q        <= row_d;
      href_q       <= href_d;
      pixel_data_q <= pixel_data_d;
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      pixel_done_q <= pixel_done_d;
      done_q       <= done_d;
      line_err_q   <= line_err_d;
    end
  end

  assign pixel_data = pixel_data_q;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign pixel_done = pixel_done_q;
  assign done       = done_q;
  assign busy       = busy_c;
  assign line_err   = line_err_q;

endmodule

// File: doc/cam_window_read.md
CAM_WINDOW_READ -- requirements
Module: cam_window_read

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning camera bus width in bits.
REQ-002 The block SHALL have parameter BPP, default 2, legal 1..4, meaning bytes per pixel.
REQ-003 The block SHALL have parameter XW, default 10, meaning column counter width.
REQ-004 The block SHALL have parameter YW, default 9, meaning row counter width.
REQ-005 The block SHALL have port p_clock, input, 1 bit: the single clock, camera pixel clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle request to begin capture.
REQ-008 The block SHALL have port continuous, input, 1 bit: 1 = capture every frame, 0 = single frame.
REQ-009 The block SHALL have ports vsync and href, inputs, 1 bit each: camera frame and line sync.
REQ-010 The block SHALL have port p_data, input, DATA_W bits: camera byte.
REQ-011 The block SHALL have ports win_x0 and win_x1, inputs, XW bits each: inclusive crop columns.
REQ-012 The block SHALL have ports win_y0 and win_y1, inputs, YW bits each: inclusive crop rows.
REQ-013 The block SHALL have port pixel_data, output, DATA_W*BPP bits: assembled pixel, first byte in MSBs.
REQ-014 The block SHALL have ports pixel_x (XW bits) and pixel_y (YW bits), outputs: full-frame coordinates of pixel_data.
REQ-015 The block SHALL have ports pixel_done, done, busy and line_err, outputs, 1 bit each: pixel valid strobe, frame-end strobe, capture active, partial-pixel error strobe.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_VS_HI, WAIT_VS_LO, CAPTURE.
REQ-017 IDLE SHALL go to WAIT_VS_HI on start, latching continuous and all four window bounds; start in any other state SHALL be ignored.
REQ-018 WAIT_VS_HI SHALL go to WAIT_VS_LO on vsync=1; WAIT_VS_LO SHALL go to CAPTURE on vsync=0.
REQ-019 In CAPTURE, vsync=1 SHALL pulse done for one cycle and go to WAIT_VS_LO if latched continuous=1, else to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 In CAPTURE each cycle with href=1 SHALL sample p_data; byte phase SHALL reset to 0 on every href rising edge.
REQ-022 After BPP bytes, the pixel SHALL be presented with pixel_done=1 one cycle after the last byte is sampled, for one cycle, only if pixel_x in [win_x0,win_x1] and pixel_y in [win_y0,win_y1].
REQ-023 pixel_x SHALL reset to 0 per line and increment per completed pixel, saturating at 2^XW-1.
REQ-024 pixel_y SHALL reset to 0 on entry to CAPTURE and increment on every href falling edge, saturating at 2^YW-1.
REQ-025 href falling with byte phase nonzero SHALL discard the partial pixel and pulse line_err for one cycle.
REQ-026 win_x0>win_x1 or win_y0>win_y1 SHALL produce no pixel_done for that frame; done SHALL still pulse.
REQ-027 vsync and href both 1 in CAPTURE SHALL be treated as frame end; the in-progress byte SHALL be discarded without line_err.

Reset
REQ-028 reset SHALL force IDLE, clear byte phase and counters, and drive pixel_data=0, pixel_x=0, pixel_y=0, pixel_done=0, done=0, busy=0, line_err=0 on the next edge, including mid-frame.
REQ-029 reset SHALL take priority over start and all camera inputs.

Configuration
REQ-030 With macro CAM_WINDOW_READ_DECIMATE_EN defined, pixel_done SHALL additionally require pixel_x[0]=0 and pixel_y[0]=0 (2:1 decimation both axes); pixel_x/pixel_y stay full-frame.
REQ-031 Without CAM_WINDOW_READ_DECIMATE_EN, no decimation logic SHALL exist and every in-window pixel SHALL be emitted.

Structure
REQ-032 Package cam_read_pkg SHALL hold the FSM state typedef and the BPP legal-range constants.
REQ-033 Byte assembly (phase counter, shift register, partial discard) SHALL be sub-module cam_byte_pack.

Verification
REQ-034 start, 4 lines x 8 bytes, BPP=2, window 0..3/0..3 -> 16 pixel_done, first pixel_data = {byte0,byte1}, done once, busy 0 after.
REQ-035 Window x 1..2, y 2..2, 4x4 pixels -> exactly 2 pixel_done at (1,2),(2,2).
REQ-036 Line of 7 bytes, BPP=2 -> 3 pixels then line_err one cycle at href fall.
REQ-037 continuous=1, 3 frames -> 3 done pulses, busy stays 1; single mode -> 1 done, second frame ignored.
REQ-038 reset asserted mid-line -> all outputs 0 next cycle, FSM IDLE, later start captures a clean frame.
REQ-039 DECIMATE_EN defined, 4x4 frame -> 4 pixels at (0,0),(2,0),(0,2),(2,2).
